reg_file_16x16: RTL and testbench
=================================

Name: reg_file_16x16

Overview:
- Sixteen-entry, 16-bit general register file; sits directly upstream of the four-input 16-bit operand select mux in the execute path.
- Two asynchronous read ports (rd_data_a, rd_data_b) drive two of the mux data inputs. A dedicated R15 read output drives a third.
- One general write port plus a dedicated R15 write port carry the upper half / remainder produced by multiply and divide.
- Write-through bypass lets a read in the same cycle as a write see the new value.

Parameters:
- DATA_W, 16, register width in bits.
- ADDR_W, 4, register address width; depth = 2**ADDR_W = 16.
- SPECIAL_REG, 15, index of the register written by the dedicated R15 port.

Ports:
- clk  input  1  system clock; all register writes on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- wr_en  input  1  general write enable.
- wr_addr  input  ADDR_W  general write address.
- wr_data  input  DATA_W  general write data.
- r15_wen  input  1  dedicated SPECIAL_REG write enable.
- r15_wdata  input  DATA_W  dedicated SPECIAL_REG write data.
- rd_addr_a  input  ADDR_W  read port A address.
- rd_addr_b  input  ADDR_W  read port B address.
- rd_data_a  output  DATA_W  read port A data.
- rd_data_b  output  DATA_W  read port B data.
- r15_rdata  output  DATA_W  current SPECIAL_REG contents, always visible.
- wr_conflict  output  1  registered flag: both write ports hit SPECIAL_REG in the previous cycle.

Behaviour:
- Reset:
  - rst_n low asynchronously clears all 16 registers and wr_conflict to 0, with no clock needed.
  - While rst_n is low, all read outputs are 0 and writes are ignored.
  - Release of rst_n is synchronous to normal operation: the first write is taken on the first rising edge with rst_n high.
- Writes:
  - On rising clk with rst_n high: if wr_en, reg[wr_addr] <= wr_data.
  - Also on that edge: if r15_wen, reg[SPECIAL_REG] <= r15_wdata.
  - Both ports may write in the same cycle to different registers; both writes take effect.
  - Simultaneous hit on SPECIAL_REG (wr_en, wr_addr == SPECIAL_REG, r15_wen): r15_wdata wins and the general write is dropped.
  - On that same edge wr_conflict <= 1; otherwise wr_conflict <= 0.
- Reads and bypass:
  - Reads are combinational, with zero-cycle latency from address change.
  - Bypass priority per read port:
    1. If r15_wen and the read address == SPECIAL_REG, output r15_wdata.
    2. Else if wr_en and the read address == wr_addr, output wr_data.
    3. Else output reg[addr].
  - r15_rdata uses the same bypass: r15_wdata if r15_wen; else wr_data if wr_en and wr_addr == SPECIAL_REG; else reg[SPECIAL_REG].
- Other rules:
  - Register 0 is an ordinary writable register; no hardwired zero.
  - No arithmetic: data passes through at full DATA_W, no truncation or extension.
  - Reset asserted mid-cycle during an active write: the write is lost, all registers read 0, and no partial update occurs.
- Latency: write-to-stored-value is 1 clk edge; write-to-read-visible is 0 cycles via bypass.

Test Plan:
- Reset:
  - Write 16'hFFFF to all 16 registers.
  - Pulse rst_n low asynchronously between edges.
  - Required: all reads immediately 0 and wr_conflict 0.
  - After release, reads remain 0 until written.
- Basic write/read:
  - Write R3=16'd50, R7=16'd100, R10=16'd5000, R15=16'd10000 via the general port.
  - Read A=R3, B=R7, then A=R10, B=R15.
  - Required: 50/100, then 5000/10000; r15_rdata = 10000.
- Bypass:
  - wr_en with wr_addr=5 and wr_data=16'd1234, with rd_addr_a=5 in the same cycle.
  - Required: rd_data_a = 1234 before the edge; stored value 1234 after the edge with wr_en low.
- Dual-port write:
  - Same edge: wr_addr=2, wr_data=16'hAAAA, and r15_wen with r15_wdata=16'h5555.
  - Required: R2=16'hAAAA, R15=16'h5555, wr_conflict=0.
- SPECIAL_REG conflict:
  - Same edge: wr_addr=15 with wr_data=16'h1111, and r15_wen with r15_wdata=16'h2222.
  - Required: R15=16'h2222; wr_conflict=1 for exactly one cycle, then 0.
- Mid-write reset:
  - Assert rst_n low while wr_en=1, wr_addr=9, wr_data=16'd77, spanning an edge.
  - Required: R9 reads 0 after release.

Source files
------------

// File: rtl/reg_file_16x16.sv
`default_nettype none
// ============================================================================
//  Module      : reg_file_16x16
//  Description : Sixteen-entry general register file with two asynchronous
//                read ports, one general write port and a dedicated write
//                port for SPECIAL_REG (R15, upper half / remainder of
//                multiply and divide). Reads bypass same-cycle writes.
//
//  Ports
//    clk         in   system clock, writes on rising edge
//    rst_n       in   asynchronous active-low reset
//    wr_en       in   general write enable
//    wr_addr     in   general write address      [ADDR_W]
//    wr_data     in   general write data         [DATA_W]
//    r15_wen     in   SPECIAL_REG write enable
//    r15_wdata   in   SPECIAL_REG write data     [DATA_W]
//    rd_addr_a   in   read port A address        [ADDR_W]
//    rd_addr_b   in   read port B address        [ADDR_W]
//    rd_data_a   out  read port A data           [DATA_W]
//    rd_data_b   out  read port B data           [DATA_W]
//    r15_rdata   out  SPECIAL_REG contents (bypassed)
//    wr_conflict out  both write ports hit SPECIAL_REG last cycle
//
//  Revision    : 1.0  initial release
// ============================================================================
module reg_file_16x16 #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 4,
    parameter int SPECIAL_REG = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              r15_wen,
    input  logic [DATA_W-1:0] r15_wdata,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic [DATA_W-1:0] r15_rdata,
    output logic              wr_conflict
);

    localparam int                c_depth        = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] c_special_addr = ADDR_W'(SPECIAL_REG);

    logic [DATA_W-1:0] r_regs [c_depth];
    logic              r_wr_conflict;

    // Both ports targeting SPECIAL_REG on the same edge: dedicated port wins.
    logic w_gen_hits_special;
    logic w_conflict;
    logic w_gen_write;

    assign w_gen_hits_special = wr_en && (wr_addr == c_special_addr);
    assign w_conflict         = w_gen_hits_special && r15_wen;
    assign w_gen_write        = wr_en && !w_conflict;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < c_depth; i++) begin
                r_regs[i] <= '0;
            end
            r_wr_conflict <= 1'b0;
        end else begin
            if (w_gen_write) begin
                r_regs[wr_addr] <= wr_data;
            end
            if (r15_wen) begin
                r_regs[SPECIAL_REG] <= r15_wdata;
            end
            r_wr_conflict <= w_conflict;
        end
    end

    // Write-through: dedicated port first, then general port, then storage.
    function automatic logic [DATA_W-1:0] f_bypass(
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] stored,
        input logic              gen_en,
        input logic [ADDR_W-1:0] gen_addr,
        input logic [DATA_W-1:0] gen_data,
        input logic              sp_en,
        input logic [DATA_W-1:0] sp_data
    );
        if (sp_en && (addr == c_special_addr)) begin
            return sp_data;
        end else if (gen_en && (addr == gen_addr)) begin
            return gen_data;
        end else begin
            return stored;
        end
    endfunction

    // Outputs are forced to zero while reset is held so that pending write
    // data on the ports cannot leak through the bypass path.
    always_comb begin
        rd_data_a = '0;
        rd_data_b = '0;
        r15_rdata = '0;
        if (rst_n) begin
            rd_data_a = f_bypass(rd_addr_a, r_regs[rd_addr_a], wr_en, wr_addr,
                                 wr_data, r15_wen, r15_wdata);
            rd_data_b = f_bypass(rd_addr_b, r_regs[rd_addr_b], wr_en, wr_addr,
                                 wr_data, r15_wen, r15_wdata);
            r15_rdata = f_bypass(c_special_addr, r_regs[SPECIAL_REG], wr_en,
                                 wr_addr, wr_data, r15_wen, r15_wdata);
        end
    end

    assign wr_conflict = r_wr_conflict;

endmodule
`default_nettype wire

// File: tb/tb_reg_file_16x16.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reg_file_16x16
//  Description : Directed-vector bench for reg_file_16x16 with an array-based
//                reference model checked every cycle plus literal checks.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_reg_file_16x16;

    logic        clk;
    logic        rst_n;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic        r15_wen;
    logic [15:0] r15_wdata;
    logic [3:0]  rd_addr_a;
    logic [3:0]  rd_addr_b;
    logic [15:0] rd_data_a;
    logic [15:0] rd_data_b;
    logic [15:0] r15_rdata;
    logic        wr_conflict;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_on  = 1'b0;

    reg_file_16x16 #(
        .DATA_W      (16),
        .ADDR_W      (4),
        .SPECIAL_REG (15)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .r15_wen     (r15_wen),
        .r15_wdata   (r15_wdata),
        .rd_addr_a   (rd_addr_a),
        .rd_addr_b   (rd_addr_b),
        .rd_data_a   (rd_data_a),
        .rd_data_b   (rd_data_b),
        .r15_rdata   (r15_rdata),
        .wr_conflict (wr_conflict)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [15:0] m_regs [16];
    logic        m_conflict;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) m_regs[i] = 16'h0;
            m_conflict = 1'b0;
        end else begin
            m_conflict = wr_en && r15_wen && (wr_addr == 4'd15);
            if (wr_en) m_regs[wr_addr] = wr_data;
            if (r15_wen) m_regs[15] = r15_wdata;   // applied last: dedicated port wins
        end
    end

    function automatic logic [15:0] exp_read(input logic [3:0] addr);
        if (!rst_n) return 16'h0;
        if (r15_wen && addr == 4'd15) return r15_wdata;
        if (wr_en && addr == wr_addr) return wr_data;
        return m_regs[addr];
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare, after inputs settle and before the next rising edge.
    always @(negedge clk) begin
        #3;
        if (chk_on) begin
            chk("model_rd_a", rd_data_a, exp_read(rd_addr_a));
            chk("model_rd_b", rd_data_b, exp_read(rd_addr_b));
            chk("model_r15", r15_rdata, exp_read(4'd15));
            chk("model_conflict", {15'h0, wr_conflict}, {15'h0, (rst_n ? m_conflict : 1'b0)});
        end
    end

    task automatic set_in(input logic we, input logic [3:0] wa, input logic [15:0] wd,
                          input logic rw, input logic [15:0] rwd,
                          input logic [3:0] ra, input logic [3:0] rb);
        wr_en = we; wr_addr = wa; wr_data = wd;
        r15_wen = rw; r15_wdata = rwd;
        rd_addr_a = ra; rd_addr_b = rb;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        rst_n = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk_on = 1'b1;
        #4;
        chk("reset_rd_a", rd_data_a, 16'h0);
        chk("reset_conflict", {15'h0, wr_conflict}, 16'h0);

        // Fill every register with all ones.
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            set_in(1, 4'(i), 16'hFFFF, 0, 0, 4'(i), 4'(i));
        end
        @(negedge clk);
        set_in(0, 0, 0, 0, 0, 0, 15);
        #4;
        chk("fill_r0", rd_data_a, 16'hFFFF);
        chk("fill_r15", rd_data_b, 16'hFFFF);

        // Asynchronous reset pulse between edges.
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_rd_a", rd_data_a, 16'h0);
        chk("async_rst_rd_b", rd_data_b, 16'h0);
        chk("async_rst_r15", r15_rdata, 16'h0);
        chk("async_rst_conflict", {15'h0, wr_conflict}, 16'h0);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            set_in(0, 0, 0, 0, 0, 4'(i), 4'(15 - i));
            #4;
            chk("post_rst_zero", rd_data_a, 16'h0);
        end

        // Basic writes through the general port.
        @(negedge clk); set_in(1, 3, 16'd50, 0, 0, 0, 0);
        @(negedge clk); set_in(1, 7, 16'd100, 0, 0, 0, 0);
        @(negedge clk); set_in(1, 10, 16'd5000, 0, 0, 0, 0);
        @(negedge clk); set_in(1, 15, 16'd10000, 0, 0, 0, 0);
        @(negedge clk); set_in(0, 0, 0, 0, 0, 3, 7);
        #4;
        chk("basic_r3", rd_data_a, 16'd50);
        chk("basic_r7", rd_data_b, 16'd100);
        @(negedge clk); set_in(0, 0, 0, 0, 0, 10, 15);
        #4;
        chk("basic_r10", rd_data_a, 16'd5000);
        chk("basic_r15", rd_data_b, 16'd10000);
        chk("basic_r15_out", r15_rdata, 16'd10000);

        // Same-cycle bypass on both read ports.
        @(negedge clk); set_in(1, 5, 16'd1234, 0, 0, 5, 5);
        #4;
        chk("bypass_a", rd_data_a, 16'd1234);
        chk("bypass_b", rd_data_b, 16'd1234);
        @(negedge clk); set_in(0, 0, 0, 0, 0, 5, 3);
        #4;
        chk("bypass_stored", rd_data_a, 16'd1234);

        // Dual-port write to different registers.
        @(negedge clk); set_in(1, 2, 16'hAAAA, 1, 16'h5555, 2, 15);
        #4;
        chk("dual_bypass_b", rd_data_b, 16'h5555);
        @(negedge clk); set_in(0, 0, 0, 0, 0, 2, 15);
        #4;
        chk("dual_r2", rd_data_a, 16'hAAAA);
        chk("dual_r15", r15_rdata, 16'h5555);
        chk("dual_conflict", {15'h0, wr_conflict}, 16'h0);

        // Both ports on R15: dedicated port wins, one-cycle flag.
        @(negedge clk); set_in(1, 15, 16'h1111, 1, 16'h2222, 15, 15);
        #4;
        chk("conf_bypass_a", rd_data_a, 16'h2222);
        chk("conf_bypass_r15", r15_rdata, 16'h2222);
        @(negedge clk); set_in(0, 0, 0, 0, 0, 15, 0);
        #4;
        chk("conf_r15", r15_rdata, 16'h2222);
        chk("conf_flag_set", {15'h0, wr_conflict}, 16'h1);
        @(negedge clk);
        #4;
        chk("conf_flag_clear", {15'h0, wr_conflict}, 16'h0);

        // General write of R15 alone is bypassed to r15_rdata.
        @(negedge clk); set_in(1, 15, 16'h0F0F, 0, 0, 0, 0);
        #4;
        chk("gen_r15_bypass", r15_rdata, 16'h0F0F);

        // Reset asserted across an edge while a write is pending.
        @(negedge clk); set_in(1, 9, 16'd77, 0, 0, 9, 9);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_gated", rd_data_a, 16'h0);
        @(negedge clk); set_in(0, 0, 0, 0, 0, 9, 15);
        #2 rst_n = 1'b1;
        #2;
        chk("midrst_r9", rd_data_a, 16'h0);
        @(negedge clk);
        #4;
        chk("midrst_r9_later", rd_data_a, 16'h0);
        chk("midrst_r15", rd_data_b, 16'h0);

        @(negedge clk);
        chk_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
